// File: rtl/uart_bus_master_if.sv
// Peripheral bus bundle driven by the UART debug master.
// Signal names follow the peripheral side's decode names.
interface uart_bus_master_if;
  logic        we;
  logic        oe;
  logic        busy;
  logic [23:0] address;
  logic [3:0]  byteSelect;
  logic [31:0] dataWrite;
  logic [31:0] dataRead;

  modport master (
    output we, oe, address, byteSelect, dataWrite,
    input  busy, dataRead
  );

  modport slave (
    input  we, oe, address, byteSelect, dataWrite,
    output busy, dataRead
  );
endinterface

// File: rtl/uart_bus_master.sv
// UART-driven debug bus master.
// Takes command frames over 8N1 serial and runs one bus read or write per frame.
// It answers with ACK (0x06) or NAK (0x15). A successful read also returns the 4 data bytes.
module uart_bus_master #(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int BUS_TIMEOUT    = 255,
  parameter int FRAME_GAP_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic               uart_tx,
  uart_bus_master_if.master  peripheralBus
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [15:0]      TO_LAST   = 16'(BUS_TIMEOUT - 1);
  localparam logic [31:0]      GAP_LIMIT = 32'(FRAME_GAP_BITS * CLOCKS_PER_BIT);
  localparam logic [7:0]       ACK = 8'h06;
  localparam logic [7:0]       NAK = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  // ---------------- receiver ----------------
  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_s3;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bits;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_err;
  logic             rx_idle;

  assign rx_idle = (rx_state == RX_IDLE);

  // Synchronise the serial line, find start bits and sample each bit at its centre.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bits  <= '0;
            // A glitch that is already high again at mid-bit is not a start bit.
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bits  <= rx_bits + 3'd1;
            if (rx_bits == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_shift;
            end else begin
              rx_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- frame / bus / transmit ----------------
  state_t           state;
  logic             cmd_write;
  logic [3:0]       bs_acc;
  logic [23:0]      addr_acc;
  logic [23:0]      data_acc;
  logic [1:0]       byte_cnt;
  logic [31:0]      gap_cnt;
  logic             gap_expired;
  logic [15:0]      bus_cnt;
  logic             we_reg, oe_reg;
  logic [23:0]      address_reg;
  logic [3:0]       bs_reg;
  logic [31:0]      dw_reg;
  logic [7:0]       resp_buf [8];
  logic [2:0]       resp_len;
  logic [2:0]       resp_idx;
  logic [7:0]       cur_byte;
  logic             tx_line;
  logic [3:0]       tx_bit;
  logic [CNT_W-1:0] tx_cnt;

  assign gap_expired = (gap_cnt > GAP_LIMIT);
  assign cur_byte    = resp_buf[resp_idx];

  assign uart_tx                  = tx_line;
  assign peripheralBus.we         = we_reg;
  assign peripheralBus.oe         = oe_reg;
  assign peripheralBus.address    = address_reg;
  assign peripheralBus.byteSelect = bs_reg;
  assign peripheralBus.dataWrite  = dw_reg;

  // Frame parser, bus access sequencer and response transmitter in one state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_write   <= 1'b0;
      bs_acc      <= '0;
      addr_acc    <= '0;
      data_acc    <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      bus_cnt     <= '0;
      we_reg      <= 1'b0;
      oe_reg      <= 1'b0;
      address_reg <= '0;
      bs_reg      <= '0;
      dw_reg      <= '0;
      resp_len    <= '0;
      resp_idx    <= '0;
      tx_line     <= 1'b1;
      tx_bit      <= '0;
      tx_cnt      <= '0;
    end else begin
      // Inter-byte gap only counts while the receiver sits idle mid-frame.
      if (!((state == S_ADDR) || (state == S_DATA)) || rx_valid || !rx_idle)
        gap_cnt <= '0;
      else if (!gap_expired)
        gap_cnt <= gap_cnt + 32'd1;

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            cmd_write <= rx_data[7];
            bs_acc    <= rx_data[3:0];
            byte_cnt  <= '0;
            if (rx_data[6:4] != 3'b000) begin
              resp_buf[0] <= NAK;
              resp_len    <= 3'd1;
              resp_idx    <= '0;
              tx_line     <= 1'b0;
              tx_bit      <= '0;
              tx_cnt      <= '0;
              state       <= S_RESP;
            end else begin
              state <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          if (rx_err) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            addr_acc <= {addr_acc[15:0], rx_data};
            if (byte_cnt == 2'd2) begin
              byte_cnt <= '0;
              if (cmd_write) begin
                state <= S_DATA;
              end else begin
                address_reg <= {addr_acc[15:0], rx_data};
                bs_reg      <= bs_acc;
                oe_reg      <= 1'b1;
                bus_cnt     <= '0;
                state       <= S_BUS;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else if (gap_expired) begin
            state <= S_IDLE;
          end
        end

        S_DATA: begin
          if (rx_err) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            data_acc <= {data_acc[15:0], rx_data};
            if (byte_cnt == 2'd3) begin
              address_reg <= addr_acc;
              bs_reg      <= bs_acc;
              dw_reg      <= {data_acc, rx_data};
              we_reg      <= 1'b1;
              bus_cnt     <= '0;
              state       <= S_BUS;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else if (gap_expired) begin
            state <= S_IDLE;
          end
        end

        S_BUS: begin
          // Completion is checked before timeout so a target finishing on the last allowed cycle still succeeds.
          if (!peripheralBus.busy) begin
            we_reg      <= 1'b0;
            oe_reg      <= 1'b0;
            resp_buf[0] <= ACK;
            if (oe_reg) begin
              resp_buf[1] <= peripheralBus.dataRead[31:24];
              resp_buf[2] <= peripheralBus.dataRead[23:16];
              resp_buf[3] <= peripheralBus.dataRead[15:8];
              resp_buf[4] <= peripheralBus.dataRead[7:0];
              resp_len    <= 3'd5;
            end else begin
              resp_len <= 3'd1;
            end
            resp_idx <= '0;
            tx_line  <= 1'b0;
            tx_bit   <= '0;
            tx_cnt   <= '0;
            state    <= S_RESP;
          end else if (bus_cnt == TO_LAST) begin
            we_reg      <= 1'b0;
            oe_reg      <= 1'b0;
            resp_buf[0] <= NAK;
            resp_len    <= 3'd1;
            resp_idx    <= '0;
            tx_line     <= 1'b0;
            tx_bit      <= '0;
            tx_cnt      <= '0;
            state       <= S_RESP;
          end else if (bus_cnt != 16'hFFFF) begin
            bus_cnt <= bus_cnt + 16'd1;
          end
        end

        S_RESP: begin
          // tx_bit: 0 = start, 1..8 = data LSB first, 9 = stop.
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              if ((resp_idx + 3'd1) < resp_len) begin
                resp_idx <= resp_idx + 3'd1;
                tx_bit   <= '0;
                tx_line  <= 1'b0;
              end else begin
                tx_line <= 1'b1;
                state   <= S_IDLE;
              end
            end else begin
              tx_bit  <= tx_bit + 4'd1;
              tx_line <= (tx_bit == 4'd8) ? 1'b1 : cur_byte[tx_bit[2:0]];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master.
// It drives command frames, models a bus target with a programmable busy length and decodes the serial replies.
module tb_uart_bus_master;
  localparam int CPB = 4;
  localparam int TO  = 8;
  localparam int GAP = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;

  int checks = 0;
  int errors = 0;

  logic        busy_drv = 1'b0;
  logic [31:0] rdata_drv = '0;
  int          wait_cycles = 0;

  uart_bus_master_if bus_if();
  assign bus_if.busy     = busy_drv;
  assign bus_if.dataRead = rdata_drv;

  uart_bus_master #(.CLOCKS_PER_BIT(CPB), .BUS_TIMEOUT(TO), .FRAME_GAP_BITS(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .peripheralBus(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          both;
    bit          unstable;
    logic [23:0] addr;
    logic [3:0]  bs;
    logic [31:0] data;
    int          len;
  } bus_rec_t;

  bus_rec_t   bus_q[$];
  logic [7:0] tx_q[$];
  int         tx_frame_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial decoder for uart_tx: samples at mid-bit on falling clock edges.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      if (!rst) begin
        b = '0;
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1) tx_frame_err++;
        tx_q.push_back(b);
      end
    end
  end

  // Bus target model and access recorder: busy stays high for the first wait_cycles strobe cycles.
  initial begin
    bus_rec_t cur;
    int slen;
    slen = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (bus_if.we || bus_if.oe) begin
        if (slen == 0) begin
          cur.wr = bus_if.we;
          cur.both = bus_if.we && bus_if.oe;
          cur.unstable = 1'b0;
          cur.addr = bus_if.address;
          cur.bs = bus_if.byteSelect;
          cur.data = bus_if.dataWrite;
        end else if (cur.addr !== bus_if.address || cur.bs !== bus_if.byteSelect ||
                     cur.data !== bus_if.dataWrite || cur.wr !== bus_if.we) begin
          cur.unstable = 1'b1;
        end
        slen++;
        busy_drv = (slen <= wait_cycles);
      end else begin
        if (slen > 0) begin
          cur.len = slen;
          bus_q.push_back(cur);
          slen = 0;
        end
        busy_drv = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  // Wait (bounded) until n reply bytes arrived, then let the line settle.
  task automatic wait_tx(input int n, input string tag);
    int budget;
    budget = 4000;
    while (tx_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({tag, "_reply_in_time"}, budget > 0, 1);
    repeat (3*CPB) @(negedge clk);
  endtask

  // One complete frame, checked against the expected reply and bus access.
  task automatic do_frame(input string tag, input bit wr, input logic [23:0] addr, input logic [3:0] bs,
                          input logic [31:0] data, input int wt, input logic [31:0] rd);
    logic [7:0] exp_q[$];
    bit ok;
    int exp_len;
    ok = (wt < TO);
    exp_len = ok ? wt + 1 : TO;
    exp_q = {};
    if (!ok) exp_q.push_back(8'h15);
    else begin
      exp_q.push_back(8'h06);
      if (!wr) begin
        exp_q.push_back(rd[31:24]);
        exp_q.push_back(rd[23:16]);
        exp_q.push_back(rd[15:8]);
        exp_q.push_back(rd[7:0]);
      end
    end
    wait_cycles = wt;
    rdata_drv = rd;
    tx_q = {};
    bus_q = {};
    send_byte({wr, 3'b000, bs}, 1'b1);
    send_byte(addr[23:16], 1'b1);
    send_byte(addr[15:8], 1'b1);
    send_byte(addr[7:0], 1'b1);
    if (wr) begin
      send_byte(data[31:24], 1'b1);
      send_byte(data[23:16], 1'b1);
      send_byte(data[15:8], 1'b1);
      send_byte(data[7:0], 1'b1);
    end
    wait_tx(exp_q.size(), tag);
    chk({tag, "_reply_count"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      chk({tag, "_reply_byte"}, tx_q[i], exp_q[i]);
    chk({tag, "_access_count"}, bus_q.size(), 1);
    if (bus_q.size() > 0) begin
      chk({tag, "_is_write"}, bus_q[0].wr, wr);
      chk({tag, "_we_and_oe"}, bus_q[0].both, 0);
      chk({tag, "_addr"}, bus_q[0].addr, addr);
      chk({tag, "_bs"}, bus_q[0].bs, bs);
      if (wr) chk({tag, "_wdata"}, bus_q[0].data, data);
      chk({tag, "_strobe_cycles"}, bus_q[0].len, exp_len);
      chk({tag, "_stable"}, bus_q[0].unstable, 0);
    end
    wait_cycles = 0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    int sel;
    int wt;
    bit wr;

    // Reset state
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_we", bus_if.we, 0);
    chk("rst_oe", bus_if.oe, 0);
    chk("rst_addr", bus_if.address, 0);
    chk("rst_bs", bus_if.byteSelect, 0);
    chk("rst_wdata", bus_if.dataWrite, 0);
    rst = 1'b0;
    repeat (4*CPB) @(negedge clk);

    // Directed examples
    do_frame("write", 1'b1, 24'h123456, 4'hF, 32'hDEADBEEF, 0, 32'h0);
    do_frame("read_wait", 1'b0, 24'h000010, 4'h3, 32'h0, 3, 32'hCAFEF00D);
    do_frame("timeout", 1'b0, 24'h000020, 4'h3, 32'h0, 1000, 32'h11223344);
    do_frame("last_ok_cycle", 1'b1, 24'hABCDEF, 4'h5, 32'h01020304, TO-1, 32'h0);
    do_frame("first_timeout", 1'b1, 24'h000001, 4'h1, 32'h55667788, TO, 32'h0);

    // Reserved command bits
    tx_q = {};
    bus_q = {};
    send_byte(8'h40, 1'b1);
    wait_tx(1, "reserved");
    chk("reserved_reply_count", tx_q.size(), 1);
    if (tx_q.size() > 0) chk("reserved_reply", tx_q[0], 8'h15);
    chk("reserved_no_access", bus_q.size(), 0);

    // Framing error: no reply, no access, next frame is fine
    tx_q = {};
    bus_q = {};
    send_byte(8'h8F, 1'b0);
    repeat (20*CPB) @(negedge clk);
    chk("framing_no_reply", tx_q.size(), 0);
    chk("framing_no_access", bus_q.size(), 0);
    do_frame("after_framing", 1'b0, 24'h00BEEF, 4'hC, 32'h0, 1, 32'h600DF00D);

    // Gap abort: partial write abandoned, following read runs alone
    send_byte(8'h8F, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat ((GAP+1)*CPB) @(negedge clk);
    do_frame("after_gap", 1'b0, 24'h000010, 4'hF, 32'h0, 0, 32'h0BADCAFE);

    // Randomised traffic
    for (int n = 0; n < 12; n++) begin
      sel = $urandom_range(0, 5);
      wt = (sel == 5) ? 40 : sel;
      wr = 1'($urandom_range(0, 1));
      do_frame("random", wr, 24'($urandom), 4'($urandom), $urandom, wt, $urandom);
    end

    // Reset in the middle of a stalled read
    wait_cycles = 1000;
    send_byte(8'h0F, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h55, 1'b1);
    budget = 500;
    while (!bus_if.oe && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("midrst_oe_seen", bus_if.oe, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_oe", bus_if.oe, 0);
    chk("midrst_we", bus_if.we, 0);
    chk("midrst_uart_tx", uart_tx, 1);
    chk("midrst_addr", bus_if.address, 0);
    chk("midrst_bs", bus_if.byteSelect, 0);
    chk("midrst_wdata", bus_if.dataWrite, 0);
    rst = 1'b0;
    wait_cycles = 0;
    repeat (4*CPB) @(negedge clk);
    do_frame("after_reset", 1'b1, 24'h00C0DE, 4'h2, 32'hA5A55A5A, 2, 32'h0);

    chk("tx_stop_bits", tx_frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
